// File: rtl/lcd_spi_writer.sv
// Serializes 9-bit {dc, byte} words from the LCD sequencer onto the ST7735 4-wire SPI
// bus (CPOL=0, CPHA=0, MSB first), with a one-cycle wr_done per byte and an inter-byte gap.
module lcd_spi_writer #(
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYC);
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE, GAP} state_t;

  state_t        state;
  logic [HW-1:0] half_cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    bit_cnt;
  logic          phase_lo;
  logic [7:0]    shift_reg;
  logic          dc_reg;
  logic          half_end;

  assign half_end = (half_cnt == H_LAST);

  // Word capture and shifting; the next bit is moved up at the end of each high
  // half-period so MOSI changes together with the SCLK falling edge.
  always_ff @(posedge sys_clk) begin
    if (state == IDLE && en_write) begin
      shift_reg <= data[7:0];
      dc_reg    <= data[8];
    end else if (state == SHIFT && !phase_lo && half_end) begin
      shift_reg <= {shift_reg[6:0], 1'b0};
    end
  end

  // Outputs are registered from the current state, so each pin lags its state by one edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      half_cnt <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
      phase_lo <= 1'b0;
      wr_done  <= 1'b0;
      busy     <= 1'b0;
      lcd_cs   <= 1'b1;
      lcd_dc   <= 1'b0;
      lcd_sclk <= 1'b0;
      lcd_mosi <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          lcd_cs   <= 1'b1;
          lcd_sclk <= 1'b0;
          if (en_write) begin
            state    <= SETUP;
            busy     <= 1'b1;
            half_cnt <= '0;
          end
        end
        SETUP: begin
          lcd_cs   <= 1'b0;
          lcd_dc   <= dc_reg;
          lcd_mosi <= shift_reg[7];
          lcd_sclk <= 1'b0;
          if (half_end) begin
            state    <= SHIFT;
            half_cnt <= '0;
            bit_cnt  <= 3'd7;
            phase_lo <= 1'b0;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        SHIFT: begin
          lcd_sclk <= ~phase_lo;
          lcd_mosi <= shift_reg[7];
          if (half_end) begin
            half_cnt <= '0;
            phase_lo <= ~phase_lo;
            if (phase_lo) begin
              if (bit_cnt == 3'd0) state <= HOLD;
              else                 bit_cnt <= bit_cnt - 3'd1;
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        HOLD: begin
          lcd_sclk <= 1'b0;
          if (half_end) begin
            state    <= DONE;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        DONE: begin
          wr_done <= 1'b1;
          lcd_cs  <= 1'b1;
          state   <= GAP;
          gap_cnt <= '0;
        end
        GAP: begin
          lcd_cs <= 1'b1;
          if (gap_cnt == G_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
